// File: rtl/fft_pkg.sv
// Shared constants, sample typedef and bit-reversal helper for the 32-point FFT pipeline.
package fft_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned N      = 32;
   localparam int unsigned LOG2N  = 5;

   typedef struct packed {
      logic signed [DATA_W-1:0] re;
      logic signed [DATA_W-1:0] im;
   } cplx_t;

   typedef enum logic {
      BANK_FREE,
      BANK_FULL
   } bank_state_t;

   function automatic logic [LOG2N-1:0] bitrev5(input logic [LOG2N-1:0] k);
      logic [LOG2N-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < LOG2N; b++) begin
         r[b] = k[LOG2N-1-b];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank frame store: one synchronous write port, one asynchronous read port.
module fft_pingpong_ram
   import fft_pkg::*;
(
   input  logic                  clk,
   input  logic                  we,
   input  logic                  wr_bank,
   input  logic [LOG2N-1:0]      wr_addr,
   input  logic [2*DATA_W-1:0]   wr_data,
   input  logic                  rd_bank,
   input  logic [LOG2N-1:0]      rd_addr,
   output logic [2*DATA_W-1:0]   rd_data
);

   logic [2*DATA_W-1:0] mem [2][N];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_bank][wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_bank][rd_addr];

endmodule

// File: rtl/fft_out_reorder.sv
// Reorders bit-reversed FFT output frames into natural bin order through a ping-pong store
// with a ready/valid output register.
module fft_out_reorder
   import fft_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_i,
   input  logic signed [DATA_W-1:0] data_in_r,
   input  logic signed [DATA_W-1:0] data_in_i,
   output logic                     ready_o,
   output logic                     overflow_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic signed [DATA_W-1:0] data_out_r,
   output logic signed [DATA_W-1:0] data_out_i,
   output logic [LOG2N-1:0]         index_o,
   output logic                     last_o
);

   localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

   bank_state_t         bank_st  [2];
   bank_state_t         bank_nxt [2];
   logic                wr_bank;
   logic                rd_bank;
   logic [LOG2N-1:0]    wr_cnt;
   logic [LOG2N-1:0]    rd_cnt;
   logic                wr_acc;
   logic                wr_done;
   logic                load;
   logic                rd_done;
   logic [2*DATA_W-1:0] rd_data;

   assign ready_o = (bank_st[wr_bank] == BANK_FREE);
   assign wr_acc  = valid_i && ready_o;
   assign wr_done = wr_acc && (wr_cnt == CNT_LAST);
   assign load    = (bank_st[rd_bank] == BANK_FULL) && (!valid_o || ready_i);
   assign rd_done = load && (rd_cnt == CNT_LAST);

   // A write can only complete on a free bank and a read only on a full one, so the two
   // updates always land on different banks.
   always_comb begin
      bank_nxt = bank_st;
      if (wr_done) begin
         bank_nxt[wr_bank] = BANK_FULL;
      end
      if (rd_done) begin
         bank_nxt[rd_bank] = BANK_FREE;
      end
   end

   fft_pingpong_ram u_ram (
      .clk     (clk),
      .we      (wr_acc),
      .wr_bank (wr_bank),
      .wr_addr (bitrev5(wr_cnt)),
      .wr_data ({data_in_r, data_in_i}),
      .rd_bank (rd_bank),
      .rd_addr (rd_cnt),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         bank_st[0] <= BANK_FREE;
         bank_st[1] <= BANK_FREE;
         wr_bank    <= 1'b0;
         rd_bank    <= 1'b0;
         wr_cnt     <= '0;
         rd_cnt     <= '0;
         overflow_o <= 1'b0;
         valid_o    <= 1'b0;
         last_o     <= 1'b0;
         index_o    <= '0;
         data_out_r <= '0;
         data_out_i <= '0;
      end else begin
         bank_st <= bank_nxt;

         if (wr_acc) begin
            if (wr_done) begin
               wr_cnt  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end

         if (valid_i && !ready_o) begin
            overflow_o <= 1'b1;
         end

         if (load) begin
            data_out_r <= rd_data[2*DATA_W-1:DATA_W];
            data_out_i <= rd_data[DATA_W-1:0];
            index_o    <= rd_cnt;
            last_o     <= (rd_cnt == CNT_LAST);
            valid_o    <= 1'b1;
            if (rd_done) begin
               rd_cnt  <= '0;
               rd_bank <= ~rd_bank;
            end else begin
               rd_cnt <= rd_cnt + 1'b1;
            end
         end else if (valid_o && ready_i) begin
            valid_o <= 1'b0;
            last_o  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: frame-level reference model plus directed literal expectations.
module tb_fft_out_reorder;
   import fft_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     valid_i;
   logic signed [DATA_W-1:0] data_in_r;
   logic signed [DATA_W-1:0] data_in_i;
   logic                     ready_o;
   logic                     overflow_o;
   logic                     valid_o;
   logic                     ready_i;
   logic signed [DATA_W-1:0] data_out_r;
   logic signed [DATA_W-1:0] data_out_i;
   logic [LOG2N-1:0]         index_o;
   logic                     last_o;

   always #5 clk = ~clk;

   fft_out_reorder dut (
      .clk        (clk),
      .rst        (rst),
      .valid_i    (valid_i),
      .data_in_r  (data_in_r),
      .data_in_i  (data_in_i),
      .ready_o    (ready_o),
      .overflow_o (overflow_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .data_out_r (data_out_r),
      .data_out_i (data_out_i),
      .index_o    (index_o),
      .last_o     (last_o)
   );

   int checks = 0;
   int errors = 0;
   bit cmp_en = 0;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int tb_bitrev(input int k);
      int r = 0;
      for (int b = 0; b < 5; b++) r = r * 2 + ((k >> b) & 1);
      return r;
   endfunction

   // Reference model: completed frames become queues of natural-order bins; the output slot
   // takes the next bin whenever it is empty or being consumed.
   typedef struct {
      int idx;
      int r;
      int i;
      bit last;
   } bin_t;

   bin_t avail[$];
   bin_t slot = '{0, 0, 0, 0};
   bit   m_valid = 0;
   bit   m_over = 0;
   int   pending = 0;
   int   cur_cnt = 0;
   int   cur_r[32];
   int   cur_i[32];
   bit   rdy_m;

   always @(posedge clk) begin
      if (rst) begin
         avail.delete();
         slot    = '{0, 0, 0, 0};
         m_valid = 0;
         m_over  = 0;
         pending = 0;
         cur_cnt = 0;
      end else begin
         rdy_m = (pending < 2);
         if (avail.size() > 0 && (!m_valid || ready_i)) begin
            slot    = avail.pop_front();
            m_valid = 1;
            if (slot.last) pending--;
         end else if (m_valid && ready_i) begin
            m_valid   = 0;
            slot.last = 0;
         end
         if (valid_i) begin
            if (rdy_m) begin
               cur_r[cur_cnt] = int'(data_in_r);
               cur_i[cur_cnt] = int'(data_in_i);
               cur_cnt++;
               if (cur_cnt == 32) begin
                  for (int j = 0; j < 32; j++)
                     avail.push_back('{j, cur_r[tb_bitrev(j)], cur_i[tb_bitrev(j)], j == 31});
                  pending++;
                  cur_cnt = 0;
               end
            end else begin
               m_over = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("ready_o", ready_o, pending < 2);
         check("overflow_o", overflow_o, m_over);
         check("valid_o", valid_o, m_valid);
         check("last_o", last_o, slot.last);
         check("index_o", index_o, slot.idx);
         check("data_out_r", data_out_r, slot.r);
         check("data_out_i", data_out_i, slot.i);
      end
   end

   task automatic step(input bit v, input int r, input int i, input bit rdy);
      valid_i   = v;
      data_in_r = DATA_W'(r);
      data_in_i = DATA_W'(i);
      ready_i   = rdy;
      @(negedge clk);
   endtask

   int rlow;

   initial begin
      rst       = 1'b1;
      valid_i   = 1'b0;
      ready_i   = 1'b0;
      data_in_r = '0;
      data_in_i = '0;
      repeat (2) @(negedge clk);
      cmp_en = 1;

      check("rst_ready", ready_o, 1);
      check("rst_valid", valid_o, 0);
      check("rst_overflow", overflow_o, 0);
      check("rst_data_r", data_out_r, 0);
      check("rst_data_i", data_out_i, 0);
      check("rst_index", index_o, 0);
      rst = 1'b0;

      // single frame
      for (int k = 0; k < 32; k++) step(1, tb_bitrev(k), -tb_bitrev(k), 1);
      check("lat_not_yet", valid_o, 0);
      step(0, 0, 0, 1);
      check("first_valid", valid_o, 1);
      check("first_index", index_o, 0);
      check("first_data_r", data_out_r, 0);
      for (int j = 1; j < 32; j++) begin
         step(0, 0, 0, 1);
         if (j == 16) check("mid_data_r", data_out_r, 16);
      end
      check("single_last", last_o, 1);
      check("single_last_i", data_out_i, -31);
      check("single_last_idx", index_o, 31);
      repeat (4) step(0, 0, 0, 1);

      // streaming
      rlow = 0;
      for (int f = 0; f < 4; f++)
         for (int k = 0; k < 32; k++) begin
            if (!ready_o) rlow++;
            step(1, tb_bitrev(k), f, 1);
         end
      repeat (40) step(0, 0, 0, 1);
      check("stream_ready_low_cycles", rlow, 0);
      check("stream_overflow", overflow_o, 0);

      // backpressure
      for (int s = 0; s < 65; s++) begin
         step(1, tb_bitrev(s % 32), 10 + s / 32, 0);
         if (s == 63) check("bp_ready_drop", ready_o, 0);
      end
      check("bp_overflow", overflow_o, 1);
      repeat (5) step(0, 0, 0, 0);
      check("bp_hold_valid", valid_o, 1);
      check("bp_hold_index", index_o, 0);
      check("bp_hold_data_i", data_out_i, 10);
      repeat (70) step(0, 0, 0, 1);

      rst = 1'b1;
      step(0, 0, 0, 0);
      rst = 1'b0;

      // random gapped input, random backpressure
      for (int c = 0; c < 400; c++)
         step($urandom_range(0, 99) < 70, int'($urandom_range(0, 65535)) - 32768,
              int'($urandom_range(0, 65535)) - 32768, 1'($urandom_range(0, 1)));
      repeat (80) step(0, 0, 0, 1);

      // reset mid-operation
      rst = 1'b1;
      step(0, 0, 0, 0);
      rst = 1'b0;
      for (int k = 0; k < 32; k++) step(1, 200 + k, k, 1);
      for (int k = 0; k < 17; k++) step(1, 300 + k, k, k >= 8);
      check("pre_rst_index", index_o, 9);
      rst = 1'b1;
      step(0, 0, 0, 1);
      rst = 1'b0;
      check("mid_rst_valid", valid_o, 0);
      check("mid_rst_index", index_o, 0);
      check("mid_rst_data_r", data_out_r, 0);
      check("mid_rst_ready", ready_o, 1);
      for (int k = 0; k < 32; k++) step(1, 500 + tb_bitrev(k), k, 1);
      step(0, 0, 0, 1);
      check("fresh_first_data_r", data_out_r, 500);
      check("fresh_first_data_i", data_out_i, 0);
      step(0, 0, 0, 1);
      check("fresh_second_data_i", data_out_i, 16);
      repeat (40) step(0, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
